uart_io_ctrl: RTL and testbench
===============================

Name: uart_io_ctrl

Overview:
Memory-mapped I/O controller that sits between the CPU's execute/memory stage and the UART. It buffers UART RX and TX bytes in FIFOs and exposes status, RX, TX and a cycle counter as registers. It also arbitrates the single UART transmitter between the CPU TX FIFO and a hardware debug byte stream.

Parameters:
TX_DEPTH, 8, TX FIFO entries; power of two, minimum 2.
RX_DEPTH, 8, RX FIFO entries; power of two, minimum 2.
IO_NIBBLE, 4'h8, value of Addr[31:28] that selects I/O space.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
Addr  in  32  CPU load/store address (ALU output)
StoreMask  in  4  byte-write mask; nonzero = store
StoreData  in  32  store data; only [7:0] used for TX
LoadEn  in  1  load strobe for Addr
LoadData  out  32  registered load data for I/O addresses
IsIO  out  1  combinational: Addr[31:28]==IO_NIBBLE; memory map uses it to suppress DMEM writes and select LoadData
DbgData  in  8  debug byte
DbgValid  in  1  debug byte valid
DbgReady  out  1  debug byte accepted this cycle
DataIn  out  8  byte to UART TX
DataInValid  out  1  UART TX valid
DataInReady  in  1  UART TX ready
DataOut  in  8  byte from UART RX
DataOutValid  in  1  UART RX valid
DataOutReady  out  1  controller accepts the RX byte

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high. All state updates on the posedge of clk.
- Reset: both FIFOs empty, cycle counter 0, LoadData 0, tx_drop 0, round-robin pointer favours CPU, grant lock clear.
- While rst is high: DataInValid=0, DbgReady=0, DataOutReady=0.
- Register map, decoded from Addr[7:0] when IsIO:
  - 0x00 status (read): [0] TX FIFO not full; [1] RX FIFO not empty; [2] tx_drop (sticky); [31:3] = 0. Reading status clears tx_drop.
  - 0x04 RX data (read): {24'b0, head byte}; pops the RX FIFO. Reading an empty RX FIFO returns 0 and does not pop.
  - 0x08 TX data (write): pushes StoreData[7:0] if the TX FIFO is not full. A write to a full FIFO is dropped and sets tx_drop.
  - 0x10 cycle counter: read returns the counter; any store resets it to 0. The 32-bit counter increments every cycle and wraps at 0xFFFFFFFF->0. A store at 0x10 wins over the increment.
  - Unmapped offsets: reads return 0; writes are ignored.
- Load timing: side effects (pop, tx_drop clear) occur in the LoadEn cycle. LoadData is valid the following cycle and holds until the next I/O load.
- RX path:
  - DataOutReady = !rx_full.
  - A push happens when DataOutValid && DataOutReady.
  - On a simultaneous push and pop, both occur and the count is unchanged.
  - The full flag is registered, so a pop while full does not admit the push in the same cycle.
- TX FIFO: on a simultaneous CPU push and arbiter pop while full, the push is accepted and tx_drop is not set.
- Arbiter (two requesters, CPU = TX FIFO non-empty, DBG = DbgValid):
  - Grant when only one requests: that requester.
  - Grant when both request: the requester favoured by the round-robin pointer.
  - DataIn and DataInValid carry the granted source.
  - When DataInValid && !DataInReady, the grant locks and must not change until the handshake completes. DataIn must stay stable during the lock.
  - On a handshake (DataInValid && DataInReady): pop the TX FIFO or pulse DbgReady, set the pointer to favour the other source, clear the lock.
  - A lone requester may transmit back-to-back.
- Pointer arithmetic: FIFO read and write pointers are log2(DEPTH) bits and wrap naturally. Full/empty are derived from a count register of log2(DEPTH)+1 bits.

Test Plan:
- Reset, then read 0x00 -> LoadData=0x00000001 next cycle; DataInValid=0; DataOutReady=1.
- Store bytes 0x41, 0x42, 0x43 to 0x08 with DataInReady held 1 -> DataIn sequence 0x41, 0x42, 0x43, one per cycle. Status bit0 stays 1.
- DataInReady=0; write 9 bytes with TX_DEPTH=8 -> status reads 0x00000004 (full, tx_drop). The next status read returns 0x00000000. Ninth byte never transmitted.
- UART delivers 0x5A then 0x7E -> status=0x00000003; read 0x04 twice gives 0x5A then 0x7E; a third read gives 0 and status bit1=0.
- CPU FIFO holds 0x11, 0x12 and DbgValid=1 with DbgData=0xD0 constant; DataInReady toggles 0,1,0,1 -> grant locked while ready=0. Transmit order 0x11, 0xD0, 0x12, 0xD0; DbgReady pulses once per debug handshake.
- Store to 0x10, then read 0x10 five cycles later -> value 4 or 5 consistent with spec timing. Preload to 0xFFFFFFFF via force -> wraps to 0.

Source files
------------

// File: rtl/uart_io_ctrl.sv
// Memory-mapped UART controller: TX/RX byte FIFOs, status/data/cycle-counter registers,
// and a round-robin arbiter sharing the UART transmitter between the CPU FIFO and a debug stream.
module uart_io_ctrl #(
    parameter int         TX_DEPTH  = 8,
    parameter int         RX_DEPTH  = 8,
    parameter logic [3:0] IO_NIBBLE = 4'h8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Addr,
    input  logic [3:0]  StoreMask,
    input  logic [31:0] StoreData,
    input  logic        LoadEn,
    output logic [31:0] LoadData,
    output logic        IsIO,
    input  logic [7:0]  DbgData,
    input  logic        DbgValid,
    output logic        DbgReady,
    output logic [7:0]  DataIn,
    output logic        DataInValid,
    input  logic        DataInReady,
    input  logic [7:0]  DataOut,
    input  logic        DataOutValid,
    output logic        DataOutReady
);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam logic [TX_AW:0] TX_FULL_COUNT = (TX_AW+1)'(TX_DEPTH);
    localparam logic [RX_AW:0] RX_FULL_COUNT = (RX_AW+1)'(RX_DEPTH);

    localparam logic [7:0] OFS_STATUS = 8'h00;
    localparam logic [7:0] OFS_RXDATA = 8'h04;
    localparam logic [7:0] OFS_TXDATA = 8'h08;
    localparam logic [7:0] OFS_CYCLE  = 8'h10;

    logic [7:0] offset;
    logic       isLoad;
    logic       isStore;
    logic       unusedBits;

    assign IsIO       = (Addr[31:28] == IO_NIBBLE);
    assign offset     = Addr[7:0];
    assign isLoad     = LoadEn && IsIO;
    assign isStore    = (StoreMask != 4'b0000) && IsIO;
    assign unusedBits = ^{Addr[27:8], StoreData[31:8]};

    // ---------------- TX FIFO ----------------
    logic [7:0]       txMem [TX_DEPTH];
    logic [TX_AW-1:0] txWrPtrReg, txRdPtrReg;
    logic [TX_AW:0]   txCountReg;
    logic             txFull, txEmpty, txPushReq, txPush, txPop;
    logic             txDropReg;

    assign txFull    = (txCountReg == TX_FULL_COUNT);
    assign txEmpty   = (txCountReg == '0);
    assign txPushReq = isStore && (offset == OFS_TXDATA);
    // A pop in the same cycle frees a slot, so a push to a full FIFO still lands.
    assign txPush    = txPushReq && (!txFull || txPop);

    always_ff @(posedge clk) begin
        if (txPush) begin
            txMem[txWrPtrReg] <= StoreData[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            txWrPtrReg <= '0;
            txRdPtrReg <= '0;
            txCountReg <= '0;
        end else begin
            if (txPush) txWrPtrReg <= txWrPtrReg + TX_AW'(1);
            if (txPop)  txRdPtrReg <= txRdPtrReg + TX_AW'(1);
            if (txPush && !txPop)      txCountReg <= txCountReg + (TX_AW+1)'(1);
            else if (!txPush && txPop) txCountReg <= txCountReg - (TX_AW+1)'(1);
        end
    end

    // ---------------- Arbiter ----------------
    logic cpuReq, dbgReq, grantDbg, handshake;
    logic lockReg, lockDbgReg, favorDbgReg;

    assign cpuReq = !txEmpty;
    assign dbgReq = DbgValid;

    always_comb begin
        grantDbg = 1'b0;
        if (lockReg) grantDbg = lockDbgReg;
        else         grantDbg = dbgReq && (!cpuReq || favorDbgReg);
    end

    assign DataInValid = !rst && (lockReg || cpuReq || dbgReq);
    assign DataIn      = grantDbg ? DbgData : txMem[txRdPtrReg];
    assign handshake   = DataInValid && DataInReady;
    assign DbgReady    = handshake && grantDbg;
    assign txPop       = handshake && !grantDbg;

    always_ff @(posedge clk) begin
        if (rst) begin
            lockReg     <= 1'b0;
            lockDbgReg  <= 1'b0;
            favorDbgReg <= 1'b0;
        end else if (handshake) begin
            lockReg     <= 1'b0;
            favorDbgReg <= !grantDbg;
        end else if (DataInValid) begin
            // Stalled transfer: freeze the chosen source until the UART takes it.
            lockReg    <= 1'b1;
            lockDbgReg <= grantDbg;
        end
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]       rxMem [RX_DEPTH];
    logic [RX_AW-1:0] rxWrPtrReg, rxRdPtrReg;
    logic [RX_AW:0]   rxCountReg;
    logic             rxFull, rxEmpty, rxPush, rxPop;

    assign rxFull       = (rxCountReg == RX_FULL_COUNT);
    assign rxEmpty      = (rxCountReg == '0);
    assign DataOutReady = !rst && !rxFull;
    assign rxPush       = DataOutValid && DataOutReady;
    assign rxPop        = isLoad && (offset == OFS_RXDATA) && !rxEmpty;

    always_ff @(posedge clk) begin
        if (rxPush) begin
            rxMem[rxWrPtrReg] <= DataOut;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rxWrPtrReg <= '0;
            rxRdPtrReg <= '0;
            rxCountReg <= '0;
        end else begin
            if (rxPush) rxWrPtrReg <= rxWrPtrReg + RX_AW'(1);
            if (rxPop)  rxRdPtrReg <= rxRdPtrReg + RX_AW'(1);
            if (rxPush && !rxPop)      rxCountReg <= rxCountReg + (RX_AW+1)'(1);
            else if (!rxPush && rxPop) rxCountReg <= rxCountReg - (RX_AW+1)'(1);
        end
    end

    // ---------------- Registers ----------------
    logic [31:0] cycleCountReg;
    logic [31:0] loadDataReg;
    logic [31:0] readValue;

    always_comb begin
        readValue = '0;
        case (offset)
            OFS_STATUS: readValue = {29'b0, txDropReg, !rxEmpty, !txFull};
            OFS_RXDATA: readValue = rxEmpty ? 32'b0 : {24'b0, rxMem[rxRdPtrReg]};
            OFS_CYCLE:  readValue = cycleCountReg;
            default:    readValue = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            loadDataReg   <= '0;
            txDropReg     <= 1'b0;
            cycleCountReg <= '0;
        end else begin
            if (isLoad) loadDataReg <= readValue;

            // A fresh drop outranks a concurrent status-read clear.
            if (txPushReq && txFull && !txPop)       txDropReg <= 1'b1;
            else if (isLoad && offset == OFS_STATUS) txDropReg <= 1'b0;

            if (isStore && offset == OFS_CYCLE) cycleCountReg <= '0;
            else                                cycleCountReg <= cycleCountReg + 32'd1;
        end
    end

    assign LoadData = loadDataReg;
endmodule

// File: tb/tb_uart_io_ctrl.sv
// Directed bench for uart_io_ctrl: register map, TX/RX FIFOs, arbitration lock and cycle counter.
module tb_uart_io_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Addr;
    logic [3:0]  StoreMask;
    logic [31:0] StoreData;
    logic        LoadEn;
    logic [31:0] LoadData;
    logic        IsIO;
    logic [7:0]  DbgData;
    logic        DbgValid;
    logic        DbgReady;
    logic [7:0]  DataIn;
    logic        DataInValid;
    logic        DataInReady;
    logic [7:0]  DataOut;
    logic        DataOutValid;
    logic        DataOutReady;

    int checks   = 0;
    int failures = 0;

    uart_io_ctrl #(.TX_DEPTH(8), .RX_DEPTH(8), .IO_NIBBLE(4'h8)) dut (
        .clk(clk), .rst(rst), .Addr(Addr), .StoreMask(StoreMask), .StoreData(StoreData),
        .LoadEn(LoadEn), .LoadData(LoadData), .IsIO(IsIO),
        .DbgData(DbgData), .DbgValid(DbgValid), .DbgReady(DbgReady),
        .DataIn(DataIn), .DataInValid(DataInValid), .DataInReady(DataInReady),
        .DataOut(DataOut), .DataOutValid(DataOutValid), .DataOutReady(DataOutReady)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs and checks happen 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        $display("check %s obs=%08h exp=%08h", tag, obs, exp);
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic ioLoad(input logic [7:0] ofs);
        Addr   = {24'h800000, ofs};
        LoadEn = 1'b1;
        tick();
        LoadEn = 1'b0;
    endtask

    task automatic ioStore(input logic [7:0] ofs, input logic [7:0] data);
        Addr      = {24'h800000, ofs};
        StoreMask = 4'hF;
        StoreData = {24'h0, data};
        tick();
        StoreMask = 4'h0;
    endtask

    initial begin
        rst = 1'b1; Addr = '0; StoreMask = '0; StoreData = '0; LoadEn = 1'b0;
        DbgData = '0; DbgValid = 1'b0; DataInReady = 1'b0; DataOut = '0; DataOutValid = 1'b0;
        tick();
        check("rst_rxready", {31'b0, DataOutReady}, 32'd0);
        check("rst_txvalid", {31'b0, DataInValid}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("reset_loaddata", LoadData, 32'd0);
        check("reset_rxready", {31'b0, DataOutReady}, 32'd1);
        check("reset_txvalid", {31'b0, DataInValid}, 32'd0);
        Addr = 32'h0000_0010;
        #1;
        check("isio_low", {31'b0, IsIO}, 32'd0);
        Addr = 32'h8000_0010;
        #1;
        check("isio_high", {31'b0, IsIO}, 32'd1);
        ioLoad(8'h00);
        check("status_reset", LoadData, 32'h0000_0001);
        ioLoad(8'h0C);
        check("unmapped_read", LoadData, 32'h0);

        // Back-to-back CPU transmission with the UART always ready.
        DataInReady = 1'b1;
        Addr = 32'h8000_0008; StoreMask = 4'hF; StoreData = 32'h41;
        tick();
        StoreData = 32'h42;
        check("tx_b2b_0_valid", {31'b0, DataInValid}, 32'd1);
        check("tx_b2b_0", {24'b0, DataIn}, 32'h41);
        tick();
        StoreData = 32'h43;
        check("tx_b2b_1", {24'b0, DataIn}, 32'h42);
        tick();
        StoreMask = 4'h0;
        check("tx_b2b_2", {24'b0, DataIn}, 32'h43);
        tick();
        check("tx_b2b_idle", {31'b0, DataInValid}, 32'd0);
        ioLoad(8'h00);
        check("status_after_b2b", LoadData, 32'h0000_0001);

        // Overfill the TX FIFO while the UART stalls.
        DataInReady = 1'b0;
        for (int i = 0; i < 9; i++) ioStore(8'h08, 8'(8'h60 + i));
        ioLoad(8'h00);
        check("status_full_drop", LoadData, 32'h0000_0004);
        ioLoad(8'h00);
        check("status_drop_cleared", LoadData, 32'h0000_0000);
        DataInReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain_%0d", i), {24'b0, DataIn}, 32'(8'h60 + i));
            tick();
        end
        check("ninth_not_sent", {31'b0, DataInValid}, 32'd0);

        // RX path.
        DataOutValid = 1'b1; DataOut = 8'h5A;
        tick();
        DataOut = 8'h7E;
        tick();
        DataOutValid = 1'b0;
        ioLoad(8'h00);
        check("status_rx2", LoadData, 32'h0000_0003);
        ioLoad(8'h04);
        check("rx_read0", LoadData, 32'h0000_005A);
        ioLoad(8'h04);
        check("rx_read1", LoadData, 32'h0000_007E);
        ioLoad(8'h04);
        check("rx_read_empty", LoadData, 32'h0);
        ioLoad(8'h00);
        check("status_rx_empty", LoadData, 32'h0000_0001);

        // Arbitration: CPU grant locked before debug arrives, then alternation.
        DataInReady = 1'b0;
        ioStore(8'h08, 8'h11);
        ioStore(8'h08, 8'h12);
        DbgValid = 1'b1; DbgData = 8'hD0;
        #1;
        check("arb_locked_cpu", {24'b0, DataIn}, 32'h11);
        tick();
        check("arb_locked_cpu2", {24'b0, DataIn}, 32'h11);
        DataInReady = 1'b1; #1;
        check("arb_hs0_data", {24'b0, DataIn}, 32'h11);
        check("arb_hs0_dbgready", {31'b0, DbgReady}, 32'd0);
        tick();
        DataInReady = 1'b0; #1;
        check("arb_wait1_data", {24'b0, DataIn}, 32'hD0);
        check("arb_wait1_dbgready", {31'b0, DbgReady}, 32'd0);
        tick();
        DataInReady = 1'b1; #1;
        check("arb_hs1_data", {24'b0, DataIn}, 32'hD0);
        check("arb_hs1_dbgready", {31'b0, DbgReady}, 32'd1);
        tick();
        DataInReady = 1'b0; #1;
        check("arb_wait2_data", {24'b0, DataIn}, 32'h12);
        tick();
        DataInReady = 1'b1; #1;
        check("arb_hs2_data", {24'b0, DataIn}, 32'h12);
        check("arb_hs2_dbgready", {31'b0, DbgReady}, 32'd0);
        tick();
        DataInReady = 1'b0; #1;
        check("arb_wait3_data", {24'b0, DataIn}, 32'hD0);
        check("arb_wait3_dbgready", {31'b0, DbgReady}, 32'd0);
        tick();
        DataInReady = 1'b1; #1;
        check("arb_hs3_data", {24'b0, DataIn}, 32'hD0);
        check("arb_hs3_dbgready", {31'b0, DbgReady}, 32'd1);
        tick();
        DbgValid = 1'b0; DataInReady = 1'b0; #1;
        check("arb_idle", {31'b0, DataInValid}, 32'd0);

        // Cycle counter: clear, read five cycles later, then wrap.
        ioStore(8'h10, 8'h00);
        for (int i = 0; i < 4; i++) tick();
        ioLoad(8'h10);
        check("cycle_after_clear", LoadData, 32'd4);
        force dut.cycleCountReg = 32'hFFFF_FFFF;
        Addr = 32'h8000_0010; LoadEn = 1'b1;
        #1;
        release dut.cycleCountReg;
        tick();
        check("cycle_max", LoadData, 32'hFFFF_FFFF);
        tick();
        LoadEn = 1'b0;
        check("cycle_wrap", LoadData, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
